// File: rtl/lsu_riscv_pkg.sv
// rtl/lsu_riscv_pkg.sv - LSU state encoding, RISC-V load/store size codes and lane helpers
package lsu_riscv_pkg;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_BUSY = 2'd1,
      LSU_DONE = 2'd2
   } lsu_state_t;

   // funct3 encodings, forwarded unchanged by the decoder
   localparam logic [2:0] LDST_B  = 3'b000;
   localparam logic [2:0] LDST_H  = 3'b001;
   localparam logic [2:0] LDST_W  = 3'b010;
   localparam logic [2:0] LDST_BU = 3'b100;
   localparam logic [2:0] LDST_HU = 3'b101;

   function automatic logic [3:0] lsu_be(input logic [2:0] size, input logic [1:0] a);
      case (size)
         LDST_B, LDST_BU: lsu_be = 4'b0001 << a;
         LDST_H, LDST_HU: lsu_be = 4'b0011 << {a[1], 1'b0};
         default:         lsu_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lsu_wd(input logic [2:0] size, input logic [31:0] wd);
      case (size)
         LDST_B, LDST_BU: lsu_wd = {4{wd[7:0]}};
         LDST_H, LDST_HU: lsu_wd = {2{wd[15:0]}};
         default:         lsu_wd = wd;
      endcase
   endfunction

   function automatic logic lsu_misaligned(input logic [2:0] size, input logic [1:0] a);
      case (size)
         LDST_B, LDST_BU: lsu_misaligned = 1'b0;
         LDST_H, LDST_HU: lsu_misaligned = a[0];
         default:         lsu_misaligned = (a != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/lsu_riscv_if.sv
// rtl/lsu_riscv_if.sv - word-wide data-memory port between the LSU and memory
interface lsu_riscv_if;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;
   logic        mem_ready;

   modport master (
      output mem_req, mem_we, mem_be, mem_addr, mem_wd,
      input  mem_rd, mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_be, mem_addr, mem_wd,
      output mem_rd, mem_ready
   );
endinterface

// File: rtl/lsu_riscv_rdata_ext.sv
// rtl/lsu_riscv_rdata_ext.sv - load lane select and sign/zero extension
module lsu_rdata_ext
   import lsu_riscv_pkg::*;
(
   input  logic [2:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] word,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[7:0];
      case (addr_lo)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      half_sel = addr_lo[1] ? word[31:16] : word[15:0];
   end

   always_comb begin
      data = word;
      case (size)
         LDST_B:  data = {{24{byte_sel[7]}}, byte_sel};
         LDST_BU: data = {24'd0, byte_sel};
         LDST_H:  data = {{16{half_sel[15]}}, half_sel};
         LDST_HU: data = {16'd0, half_sel};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/lsu_riscv.sv
// rtl/lsu_riscv.sv - load/store unit with stall handshake; LSU_MISALIGN_EN rejects misaligned H/W accesses
module lsu_riscv
   import lsu_riscv_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         core_req_i,
   input  logic         core_we_i,
   input  logic [2:0]   core_size_i,
   input  logic [31:0]  core_addr_i,
   input  logic [31:0]  core_wd_i,
   output logic [31:0]  core_rd_o,
   output logic         core_stall_o,
   output logic         bus_err_o,
   output logic         misalign_o,
   lsu_riscv_if.master  mem
);

   localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [31:0] TMO_LAST = TMO_EN ? TIMEOUT_CYCLES - 1 : 32'd0;

   lsu_state_t  state_q, state_d;
   logic        we_q;
   logic [2:0]  size_q;
   logic [31:0] addr_q;
   logic [31:0] wd_q;
   logic [3:0]  be_q;
   logic [31:0] rd_q;
   logic [31:0] tmo_cnt_q;
   logic        err_q;
   logic        mis_q;
   logic        mis_req;
   logic        tmo_hit;
   logic [31:0] ext_data;

`ifdef LSU_MISALIGN_EN
   assign mis_req = lsu_misaligned(core_size_i, core_addr_i[1:0]);
`else
   assign mis_req = 1'b0;
`endif

   // ready in the expiry cycle wins, so the timeout only fires without it
   assign tmo_hit = TMO_EN && (state_q == LSU_BUSY) && !mem.mem_ready
                    && (tmo_cnt_q == TMO_LAST);

   lsu_rdata_ext u_rdata_ext (
      .size    (size_q),
      .addr_lo (addr_q[1:0]),
      .word    (mem.mem_rd),
      .data    (ext_data)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= LSU_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         LSU_IDLE: if (core_req_i) state_d = mis_req ? LSU_DONE : LSU_BUSY;
         LSU_BUSY: if (mem.mem_ready || tmo_hit) state_d = LSU_DONE;
         default:  state_d = LSU_IDLE;
      endcase
   end

   always_comb begin
      mem.mem_req  = (state_q == LSU_BUSY);
      mem.mem_we   = (state_q == LSU_BUSY) && we_q;
      mem.mem_be   = (state_q == LSU_BUSY) ? be_q : 4'b0000;
      mem.mem_addr = {addr_q[31:2], 2'b00};
      mem.mem_wd   = wd_q;
      core_stall_o = (state_q == LSU_IDLE) ? core_req_i : (state_q == LSU_BUSY);
      core_rd_o    = rd_q;
      bus_err_o    = err_q;
      misalign_o   = mis_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         we_q      <= 1'b0;
         size_q    <= 3'd0;
         addr_q    <= 32'd0;
         wd_q      <= 32'd0;
         be_q      <= 4'd0;
         rd_q      <= 32'd0;
         tmo_cnt_q <= 32'd0;
         err_q     <= 1'b0;
         mis_q     <= 1'b0;
      end else begin
         err_q <= tmo_hit;
         mis_q <= (state_q == LSU_IDLE) && core_req_i && mis_req;
         case (state_q)
            LSU_IDLE: begin
               if (core_req_i) begin
                  we_q      <= core_we_i;
                  size_q    <= core_size_i;
                  addr_q    <= core_addr_i;
                  wd_q      <= lsu_wd(core_size_i, core_wd_i);
                  be_q      <= lsu_be(core_size_i, core_addr_i[1:0]);
                  tmo_cnt_q <= 32'd0;
                  if (mis_req) rd_q <= 32'd0;
               end
            end
            LSU_BUSY: begin
               // extraction happens at capture so a later store cannot disturb core_rd_o
               if (mem.mem_ready) begin
                  if (!we_q) rd_q <= ext_data;
               end else if (tmo_hit) begin
                  if (!we_q) rd_q <= 32'd0;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 32'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_riscv.sv
// tb/tb_lsu_riscv.sv - directed self-checking bench for lsu_riscv
module tb_lsu_riscv;
   import lsu_riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        core_req;
   logic        core_we;
   logic [2:0]  core_size;
   logic [31:0] core_addr;
   logic [31:0] core_wd;
   logic [31:0] core_rd;
   logic        core_stall;
   logic        bus_err;
   logic        misalign;

   int n_cmp = 0;
   int n_bad = 0;

   int          stall_n, busy_n;
   logic        obs_we, obs_err, obs_mis;
   logic [3:0]  obs_be;
   logic [31:0] obs_addr, obs_wd, obs_rd;

   lsu_riscv_if mem_bus ();

   lsu_riscv #(.TIMEOUT_CYCLES(4)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .core_req_i   (core_req),
      .core_we_i    (core_we),
      .core_size_i  (core_size),
      .core_addr_i  (core_addr),
      .core_wd_i    (core_wd),
      .core_rd_o    (core_rd),
      .core_stall_o (core_stall),
      .bus_err_o    (bus_err),
      .misalign_o   (misalign),
      .mem          (mem_bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // drives one access; memory raises ready in BUSY cycle ready_at (0 = never)
   task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rword, input int ready_at);
      bit done;
      done    = 1'b0;
      stall_n = 0;
      busy_n  = 0;
      obs_we  = 1'b0; obs_be = 4'd0; obs_addr = 32'd0; obs_wd = 32'd0;
      @(negedge clk);
      core_req  = 1'b1;
      core_we   = we;
      core_size = size;
      core_addr = addr;
      core_wd   = wd;
      mem_bus.mem_ready = 1'b0;
      for (int cyc = 0; cyc < 20 && !done; cyc++) begin
         #1;
         if (core_stall) stall_n++;
         if (mem_bus.mem_req) begin
            busy_n++;
            obs_we   = mem_bus.mem_we;
            obs_be   = mem_bus.mem_be;
            obs_addr = mem_bus.mem_addr;
            obs_wd   = mem_bus.mem_wd;
            mem_bus.mem_rd    = rword;
            mem_bus.mem_ready = (busy_n == ready_at);
         end else if (!core_stall) begin
            done     = 1'b1;
            obs_rd   = core_rd;
            obs_err  = bus_err;
            obs_mis  = misalign;
            core_req = 1'b0;
         end
         if (!done) @(negedge clk);
      end
      mem_bus.mem_ready = 1'b0;
      if (!done) check_eq("access_bound", 32'd0, 32'd1);
   endtask

   initial begin
      rst = 1'b1; core_req = 1'b0; core_we = 1'b0; core_size = LDST_W;
      core_addr = 32'd0; core_wd = 32'd0;
      mem_bus.mem_rd = 32'd0; mem_bus.mem_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_eq("rst_mem_req", 32'(mem_bus.mem_req), 32'd0);
      check_eq("rst_stall",   32'(core_stall), 32'd0);
      check_eq("rst_rd",      core_rd, 32'd0);
      check_eq("rst_err",     32'(bus_err), 32'd0);
      check_eq("rst_mis",     32'(misalign), 32'd0);
      rst = 1'b0;

      access(1'b1, LDST_W, 32'h100, 32'hDEADBEEF, 32'h0, 2);
      check_eq("sw_be",    32'(obs_be), 32'hF);
      check_eq("sw_addr",  obs_addr, 32'h100);
      check_eq("sw_wd",    obs_wd, 32'hDEADBEEF);
      check_eq("sw_we",    32'(obs_we), 32'd1);
      check_eq("sw_stall", 32'(stall_n), 32'd3);
      check_eq("sw_busy",  32'(busy_n), 32'd2);
      check_eq("sw_rd",    obs_rd, 32'd0);

      access(1'b1, LDST_B, 32'h103, 32'h000000A5, 32'h0, 1);
      check_eq("sb_be",    32'(obs_be), 32'h8);
      check_eq("sb_wd",    obs_wd, 32'hA5A5A5A5);
      check_eq("sb_we",    32'(obs_we), 32'd1);
      check_eq("sb_addr",  obs_addr, 32'h100);
      check_eq("sb_rd",    obs_rd, 32'd0);

      access(1'b0, LDST_B, 32'h102, 32'h0, 32'h00800000, 1);
      check_eq("lb_rd",    obs_rd, 32'hFFFFFF80);
      check_eq("lb_be",    32'(obs_be), 32'h4);
      check_eq("lb_we",    32'(obs_we), 32'd0);
      access(1'b0, LDST_BU, 32'h102, 32'h0, 32'h00800000, 1);
      check_eq("lbu_rd",   obs_rd, 32'h00000080);

      access(1'b0, LDST_H, 32'h102, 32'h0, 32'h80011234, 1);
      check_eq("lh_rd",    obs_rd, 32'hFFFF8001);
      check_eq("lh_be",    32'(obs_be), 32'hC);
      access(1'b0, LDST_HU, 32'h102, 32'h0, 32'h80011234, 1);
      check_eq("lhu_rd",   obs_rd, 32'h00008001);

      access(1'b1, LDST_H, 32'h102, 32'h00001234, 32'hFFFFFFFF, 1);
      check_eq("sh_be",    32'(obs_be), 32'hC);
      check_eq("sh_wd",    obs_wd, 32'h12341234);
      check_eq("sh_rd_kept", obs_rd, 32'h00008001);

      access(1'b0, LDST_W, 32'h104, 32'h0, 32'h12345678, 3);
      check_eq("lw_rd",    obs_rd, 32'h12345678);
      check_eq("lw_stall", 32'(stall_n), 32'd4);

      access(1'b1, 3'b011, 32'h101, 32'hCAFEF00D, 32'h0, 1);
      check_eq("undef_be", 32'(obs_be), 32'hF);
      check_eq("undef_wd", obs_wd, 32'hCAFEF00D);

      access(1'b0, LDST_W, 32'h200, 32'h0, 32'h55555555, 0);
      check_eq("tmo_busy",  32'(busy_n), 32'd4);
      check_eq("tmo_stall", 32'(stall_n), 32'd5);
      check_eq("tmo_err",   32'(obs_err), 32'd1);
      check_eq("tmo_rd",    obs_rd, 32'd0);
      @(negedge clk); #1;
      check_eq("tmo_err_pulse", 32'(bus_err), 32'd0);

`ifdef LSU_MISALIGN_EN
      access(1'b0, LDST_W, 32'h101, 32'h0, 32'hA1B2C3D4, 1);
      check_eq("mis_pulse", 32'(obs_mis), 32'd1);
      check_eq("mis_busy",  32'(busy_n), 32'd0);
      check_eq("mis_rd",    obs_rd, 32'd0);
      @(negedge clk); #1;
      check_eq("mis_once",  32'(misalign), 32'd0);
`else
      access(1'b0, LDST_W, 32'h101, 32'h0, 32'hA1B2C3D4, 1);
      check_eq("mis_tied",  32'(obs_mis), 32'd0);
      check_eq("mis_be",    32'(obs_be), 32'hF);
      check_eq("mis_addr",  obs_addr, 32'h100);
      check_eq("mis_rd",    obs_rd, 32'hA1B2C3D4);
`endif

      @(negedge clk);
      core_req = 1'b1; core_we = 1'b0; core_size = LDST_W; core_addr = 32'h300;
      @(negedge clk); #1;
      check_eq("rst_busy_req", 32'(mem_bus.mem_req), 32'd1);
      rst = 1'b1; core_req = 1'b0;
      @(negedge clk); #1;
      check_eq("rst_abort_req",   32'(mem_bus.mem_req), 32'd0);
      check_eq("rst_abort_stall", 32'(core_stall), 32'd0);
      rst = 1'b0;
      @(negedge clk); #1;
      check_eq("rst_idle_req", 32'(mem_bus.mem_req), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
